// File: rtl/softmax_result_buffer_pkg.sv
// Shared Q6.10 constants and checker state encoding for the softmax result buffer.
package softmax_pkg;
  localparam int Q_FRAC    = 10;
  localparam int Q_ONE     = 1 << Q_FRAC;
  localparam int LANE_W    = 16;
  localparam int N_LANES   = 8;
  localparam int DEF_TOL   = 32;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_CHECK = 2'b10
  } chk_state_t;
endpackage

// File: rtl/softmax_result_buffer_if.sv
// Capture/readout handshake between the softmax datapath, the result buffer and its consumer.
interface softmax_result_buffer_if
  import softmax_pkg::*;
#(
  parameter int N = N_LANES,
  parameter int W = LANE_W
);
  logic           valid_in;
  logic [N*W-1:0] in_y_flat;
  logic           ready_out;
  logic           rd_en;
  logic           out_valid;
  logic [N*W-1:0] out_y_flat;

  modport master (
    output valid_in, in_y_flat, rd_en,
    input  ready_out, out_valid, out_y_flat
  );

  modport slave (
    input  valid_in, in_y_flat, rd_en,
    output ready_out, out_valid, out_y_flat
  );
endinterface

// File: rtl/softmax_result_buffer_vec_fifo.sv
// First-word-fall-through vector FIFO; a push into a full FIFO is accepted only alongside a pop.
module vec_fifo #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_push_acc,
  output logic             o_drop
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_acc;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_pop_acc  = i_pop && !o_empty;
  assign o_push_acc = i_push && (!o_full || w_pop_acc);
  assign o_drop     = i_push && !o_push_acc;
  assign o_count    = r_count;
  // Head is forced to zero while empty so stale entries never leak out.
  assign o_data     = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (o_push_acc) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({o_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/softmax_result_buffer.sv
// Buffers softmax output vectors in a FWFT FIFO and serially checks each captured lane sum against 1.0.
// Optional SOFTMAX_RB_ERRCNT_EN adds a saturating 8-bit count of failed checks (o_err_count).
module softmax_result_buffer
  import softmax_pkg::*;
#(
  parameter  int N     = N_LANES,
  parameter  int W     = LANE_W,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int TOL   = DEF_TOL,
  parameter  int ONE   = Q_ONE,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int IW    = $clog2(N),
  localparam int SW    = W + IW,
  localparam int DW    = SW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  softmax_result_buffer_if.slave bus,
  output logic [CW-1:0]         o_count,
  output logic                  o_overflow,
  output logic                  o_sum_busy,
  output logic                  o_sum_done,
  output logic [SW-1:0]         o_sum_value,
  output logic                  o_sum_err
`ifdef SOFTMAX_RB_ERRCNT_EN
  ,
  output logic [7:0]            o_err_count
`endif
);
  logic           w_full;
  logic           w_empty;
  logic           w_push_acc;
  logic           w_drop;
  logic           r_overflow;

  vec_fifo #(
    .WIDTH (N*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (bus.valid_in),
    .i_data     (bus.in_y_flat),
    .i_pop      (bus.rd_en),
    .o_data     (bus.out_y_flat),
    .o_count    (o_count),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_push_acc (w_push_acc),
    .o_drop     (w_drop)
  );

  assign bus.ready_out = !w_full;
  assign bus.out_valid = !w_empty;
  assign o_overflow    = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // state | meaning
  // IDLE  | waiting for an accepted write to start a check
  // ACCUM | adding one lane per cycle from the shadow copy
  // CHECK | sum_done pulse; sum_value/sum_err valid
  chk_state_t     r_state;
  logic [N*W-1:0] r_shadow;
  logic [IW-1:0]  r_idx;
  logic [SW-1:0]  r_acc;
  logic           r_sum_busy;
  logic           r_sum_done;
  logic [SW-1:0]  r_sum_value;
  logic           r_sum_err;
  logic [W-1:0]   w_lane;
  logic [SW-1:0]  w_acc_next;
  logic [DW-1:0]  w_diff;
  logic           w_err;

  // Shadow shifts right each cycle, so the lane being added is always the bottom one.
  assign w_lane     = r_shadow[W-1:0];
  assign w_acc_next = r_acc + SW'(w_lane);
  assign w_diff     = (w_acc_next >= SW'(ONE)) ? (DW'(w_acc_next) - DW'(ONE))
                                               : (DW'(ONE) - DW'(w_acc_next));
  assign w_err      = (w_diff > DW'(TOL));

`ifdef SOFTMAX_RB_ERRCNT_EN
  logic [7:0] r_err_count;
  assign o_err_count = r_err_count;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shadow    <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_sum_busy  <= 1'b0;
      r_sum_done  <= 1'b0;
      r_sum_value <= '0;
      r_sum_err   <= 1'b0;
`ifdef SOFTMAX_RB_ERRCNT_EN
      r_err_count <= '0;
`endif
    end else begin
      r_sum_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_push_acc) begin
            r_shadow   <= bus.in_y_flat;
            r_acc      <= '0;
            r_idx      <= '0;
            r_sum_busy <= 1'b1;
            r_state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_acc    <= w_acc_next;
          r_shadow <= r_shadow >> W;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == IW'(N-1)) begin
            r_state     <= ST_CHECK;
            r_sum_busy  <= 1'b0;
            r_sum_done  <= 1'b1;
            r_sum_value <= w_acc_next;
            r_sum_err   <= w_err;
`ifdef SOFTMAX_RB_ERRCNT_EN
            if (w_err && (r_err_count != 8'hFF)) begin
              r_err_count <= r_err_count + 8'd1;
            end
`endif
          end
        end
        ST_CHECK: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sum_busy  = r_sum_busy;
  assign o_sum_done  = r_sum_done;
  assign o_sum_value = r_sum_value;
  assign o_sum_err   = r_sum_err;
endmodule

// File: tb/tb_softmax_result_buffer.sv
// Directed self-checking bench for softmax_result_buffer (FIFO behaviour and lane-sum checker).
module tb_softmax_result_buffer;
  import softmax_pkg::*;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int VW = N * W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  count;
  logic        overflow;
  logic        sum_busy;
  logic        sum_done;
  logic [18:0] sum_value;
  logic        sum_err;
`ifdef SOFTMAX_RB_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  softmax_result_buffer_if bus ();

  softmax_result_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_sum_busy  (sum_busy),
    .o_sum_done  (sum_done),
    .o_sum_value (sum_value),
    .o_sum_err   (sum_err)
`ifdef SOFTMAX_RB_ERRCNT_EN
    ,
    .o_err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] mkvec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.rd_en = 1'b0;
    bus.in_y_flat = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single write into an empty buffer, then wait for the check and pop the vector.
  task automatic check_vec(input string name, input logic [VW-1:0] vec,
                           input int exp_sum, input logic exp_err);
    int lat;
    bit seen;
    bus.valid_in = 1'b1;
    bus.in_y_flat = vec;
    tick();
    bus.valid_in = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL %s_count1: got %0d expected 1", name, count); end
    n_checks++; if (bus.out_y_flat !== vec) begin n_fail++; $display("FAIL %s_head: got %h expected %h", name, bus.out_y_flat, vec); end
    lat = 1;
    seen = 0;
    while (!seen && lat < 20) begin
      if (sum_done === 1'b1) seen = 1;
      else begin tick(); lat++; end
    end
    n_checks++; if (!seen || lat != 9) begin n_fail++; $display("FAIL %s_latency: got %0d (seen=%0d) expected 9", name, lat, seen); end
    n_checks++; if (sum_value !== 19'(exp_sum)) begin n_fail++; $display("FAIL %s_sum: got %0d expected %0d", name, sum_value, exp_sum); end
    n_checks++; if (sum_err !== exp_err) begin n_fail++; $display("FAIL %s_err: got %0d expected %0d", name, sum_err, exp_err); end
    tick();
    n_checks++; if (sum_done !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: got %0d expected 0", name, sum_done); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL %s_count0: got %0d expected 0", name, count); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0d expected 0", bus.out_valid); end
    n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0d expected 1", bus.ready_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0d expected 0", overflow); end
    n_checks++; if (sum_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0d expected 0", sum_busy); end
    n_checks++; if (sum_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0d expected 0", sum_done); end
    n_checks++; if (sum_value !== 19'd0) begin n_fail++; $display("FAIL rst_sum: got %0d expected 0", sum_value); end
    n_checks++; if (sum_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0d expected 0", sum_err); end
    n_checks++; if (bus.out_y_flat !== '0) begin n_fail++; $display("FAIL rst_head: got %h expected 0", bus.out_y_flat); end
    // rd_en while empty must be harmless
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_pop_count: got %0d expected 0", count); end
  endtask

  task automatic test_uniform();
    do_reset();
    check_vec("uniform", {8{16'h0080}}, 1024, 1'b0);
  endtask

  task automatic test_sums();
    do_reset();
    check_vec("zeros", '0, 0, 1'b1);
    check_vec("s352", {96'd0, 16'h0060, 16'h0100}, 352, 1'b1);
    check_vec("s1050", {16'h009A, {7{16'h0080}}}, 1050, 1'b0);
    check_vec("s1056", {112'd0, 16'h0420}, 1056, 1'b0);
    check_vec("s1057", {112'd0, 16'h0421}, 1057, 1'b1);
    check_vec("s992", {112'd0, 16'h03E0}, 992, 1'b0);
    check_vec("s991", {112'd0, 16'h03DF}, 991, 1'b1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.valid_in = 1'b1;
      bus.in_y_flat = mkvec(10 * (i + 1));
      tick();
    end
    bus.valid_in = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_full: got %0d expected 4", count); end
    n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %0d expected 0", bus.ready_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %0d expected 0", overflow); end
    bus.valid_in = 1'b1;
    bus.in_y_flat = mkvec(99);
    tick();
    bus.valid_in = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_after: got %0d expected 4", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0d expected 1", overflow); end
    n_checks++; if (bus.out_y_flat !== mkvec(10)) begin n_fail++; $display("FAIL ovf_head: got %h expected %h", bus.out_y_flat, mkvec(10)); end
    tick();
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0d expected 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.valid_in = 1'b1;
      bus.in_y_flat = mkvec(10 * (i + 1));
      tick();
    end
    bus.in_y_flat = mkvec(50);
    bus.rd_en = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.rd_en = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL pp_count: got %0d expected 4", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow: got %0d expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_y_flat !== mkvec(10 * (i + 2))) begin
        n_fail++; $display("FAIL pp_order%0d: got %h expected %h", i, bus.out_y_flat, mkvec(10 * (i + 2)));
      end
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %0d expected 0", bus.out_valid); end
    n_checks++; if (bus.out_y_flat !== '0) begin n_fail++; $display("FAIL pp_head_zero: got %h expected 0", bus.out_y_flat); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [18:0] got_sum;
    logic got_err;
    do_reset();
    pulses = 0;
    got_sum = '0;
    got_err = 1'b0;
    bus.valid_in = 1'b1;
    bus.in_y_flat = {8{16'h0080}};
    tick();
    bus.in_y_flat = '0;
    tick();
    bus.valid_in = 1'b0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", count); end
    for (int i = 0; i < 20; i++) begin
      if (sum_done === 1'b1) begin pulses++; got_sum = sum_value; got_err = sum_err; end
      tick();
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
    n_checks++; if (got_sum !== 19'd1024) begin n_fail++; $display("FAIL b2b_sum: got %0d expected 1024", got_sum); end
    n_checks++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %0d expected 0", got_err); end
    n_checks++; if (bus.out_y_flat !== {8{16'h0080}}) begin n_fail++; $display("FAIL b2b_headA: got %h expected %h", bus.out_y_flat, {8{16'h0080}}); end
    bus.rd_en = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_y_flat !== '0) begin n_fail++; $display("FAIL b2b_headB: got valid=%0d data=%h expected valid=1 data=0", bus.out_valid, bus.out_y_flat); end
    tick();
    bus.rd_en = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d expected 0", count); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    pulses = 0;
    bus.valid_in = 1'b1;
    bus.in_y_flat = mkvec(1);
    tick();
    bus.valid_in = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (sum_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %0d expected 1", sum_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (sum_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %0d expected 0", sum_busy); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %0d expected 0", bus.out_valid); end
    for (int i = 0; i < 15; i++) begin
      if (sum_done === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d expected 0", pulses); end
    n_checks++; if (sum_value !== 19'd0) begin n_fail++; $display("FAIL mid_sum: got %0d expected 0", sum_value); end
  endtask

`ifdef SOFTMAX_RB_ERRCNT_EN
  task automatic test_err_count();
    do_reset();
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL errcnt_rst: got %0d expected 0", err_count); end
    check_vec("ec0", '0, 0, 1'b1);
    check_vec("ec1", {16'h0100, 112'd0}, 256, 1'b1);
    check_vec("ecok", {8{16'h0080}}, 1024, 1'b0);
    check_vec("ec2", {112'd0, 16'h0500}, 1280, 1'b1);
    n_checks++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL errcnt_three: got %0d expected 3", err_count); end
  endtask
`endif

  initial begin
    bus.valid_in = 1'b0;
    bus.rd_en = 1'b0;
    bus.in_y_flat = '0;
    test_reset();
    test_uniform();
    test_sums();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
`ifdef SOFTMAX_RB_ERRCNT_EN
    test_err_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
